// File: rtl/intra_pkg.sv
// intra_pkg: shared types, widths, neighbour indices and pixel clipping for luma 4x4 intra reconstruction
package intra_pkg;
  localparam int PIX_W = 8;
  localparam int RES_W = 9;
  typedef enum logic [2:0] {M_V, M_H, M_DDL, M_DDR, M_VR, M_HD, M_VL, M_HU} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RECON, S_DRAIN, S_DONE} state_e;
  // Positions in the unified edge L,K,J,I,M,A..H; p[-1,k] sits at N_I-k and p[k,-1] at N_A+k.
  localparam logic [3:0] N_L = 4'd0;
  localparam logic [3:0] N_K = 4'd1;
  localparam logic [3:0] N_J = 4'd2;
  localparam logic [3:0] N_I = 4'd3;
  localparam logic [3:0] N_M = 4'd4;
  localparam logic [3:0] N_A = 4'd5;
  localparam logic [3:0] N_B = 4'd6;
  localparam logic [3:0] N_C = 4'd7;
  localparam logic [3:0] N_D = 4'd8;
  localparam logic [3:0] N_E = 4'd9;
  localparam logic [3:0] N_F = 4'd10;
  localparam logic [3:0] N_G = 4'd11;
  localparam logic [3:0] N_H = 4'd12;
  function automatic logic [PIX_W-1:0] clip_pix(input logic [9:0] s);
    return s[9] ? 8'd0 : s[8] ? 8'hff : s[7:0];
  endfunction
endpackage

// File: rtl/pred_luma4x4.sv
// pred_luma4x4: combinational H.264 luma 4x4 intra predictor for one raster position
// in: mode, top (A..H), left (M,I,J,K,L), idx (row*4+col); out: pred
module pred_luma4x4
  import intra_pkg::*;
(
  input  mode_e       mode,
  input  logic [63:0] top,
  input  logic [39:0] left,
  input  logic [3:0]  idx,
  output logic [7:0]  pred
);
  logic [12:0][7:0] e;
  logic [3:0] a, b, c;
  logic two;
  logic [9:0] s;
  int x, y, z, k;
  assign e = {top, left[7:0], left[15:8], left[23:16], left[31:24], left[39:32]};
  // Every mode reduces to (a+b+1)>>1 or (a+2b+c+2)>>2 over three edge taps; copies of one tap give plain values.
  always_comb begin
    x = int'(idx[1:0]);
    y = int'(idx[3:2]);
    z = 0;
    k = 0;
    two = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    case (mode)
      M_V: begin a = 4'(N_A + x); b = a; c = a; end
      M_H: begin a = 4'(N_I - y); b = a; c = a; end
      M_DDL: begin
        if (idx == 4'd15) begin a = N_G; b = N_H; c = N_H; end
        else begin a = 4'(N_A + x + y); b = a + 4'd1; c = a + 4'd2; end
      end
      M_DDR: begin a = 4'(N_I + x - y); b = a + 4'd1; c = a + 4'd2; end
      M_VR: begin
        z = 2 * x - y;
        k = x - (y >> 1);
        if (z < -1) begin a = 4'(4 - y); b = a + 4'd1; c = a + 4'd2; end
        else if (!z[0]) begin two = 1'b1; a = 4'(N_M + k); b = a + 4'd1; end
        else begin a = 4'(N_I + k); b = a + 4'd1; c = a + 4'd2; end
      end
      M_HD: begin
        z = 2 * y - x;
        k = y - (x >> 1);
        if (z < -1) begin a = 4'(2 + x); b = a + 4'd1; c = a + 4'd2; end
        else if (!z[0]) begin two = 1'b1; a = 4'(N_I - k); b = a + 4'd1; end
        else begin a = 4'(N_I - k); b = a + 4'd1; c = a + 4'd2; end
      end
      M_VL: begin
        k = x + (y >> 1);
        two = ~idx[2];
        a = 4'(N_A + k);
        b = a + 4'd1;
        c = a + 4'd2;
      end
      default: begin
        z = x + 2 * y;
        k = y + (x >> 1);
        if (z > 5) begin a = N_L; b = N_L; c = N_L; end
        else if (z == 5) begin a = N_K; b = N_L; c = N_L; end
        else begin two = ~z[0]; a = z[0] ? 4'(1 - k) : 4'(2 - k); b = a + 4'd1; c = a + 4'd2; end
      end
    endcase
    s = two ? ({2'b00, e[a]} + {2'b00, e[b]} + 10'd1) >> 1
            : ({2'b00, e[a]} + {1'b0, e[b], 1'b0} + {2'b00, e[c]} + 10'd2) >> 2;
  end
  assign pred = s[7:0];
endmodule

// File: rtl/recon_luma4x4.sv
// recon_luma4x4: rebuilds one luma 4x4 block as clip(pred + residual) over valid/ready streams
// ctrl: clk, reset (sync, high), enable (global stall), start/mode/top/left (block setup), busy, done
// in stream: res_valid/res_ready/res_data; out stream: pix_valid/pix_ready/pix_data/pix_idx
// RECON_EDGE_EN adds edge_bottom (pixels 12..15) and edge_right (pixels 3,7,11,15) for the next block.
module recon_luma4x4
  import intra_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [63:0]      top,
  input  logic [39:0]      left,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  output logic             res_ready,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [3:0]       pix_idx,
  input  logic             pix_ready,
  output logic             busy,
`ifdef RECON_EDGE_EN
  output logic [31:0]      edge_bottom,
  output logic [31:0]      edge_right,
`endif
  output logic             done
);
  state_e state, state_nx;
  mode_e mode_q;
  logic [63:0] top_q;
  logic [39:0] left_q;
  logic [3:0] idx;
  logic [7:0] pred, pix_nx;
  logic res_acc, pix_take, start_acc;
  pred_luma4x4 u_pred (.mode(mode_q), .top(top_q), .left(left_q), .idx(idx), .pred(pred));
  // A new pixel may load in the same cycle the held one is taken, giving one pixel per clock.
  assign res_ready = enable && state == S_RECON && (!pix_valid || pix_ready);
  assign res_acc = res_ready && res_valid;
  assign pix_take = enable && pix_valid && pix_ready;
  assign start_acc = enable && start && state == S_IDLE;
  assign pix_nx = clip_pix({res_data[RES_W-1], res_data} + {2'b00, pred});
  assign busy = state == S_RECON || state == S_DRAIN;
  assign done = state == S_DONE;
  always_comb begin
    state_nx = state;
    if (enable)
      state_nx = state == S_IDLE  ? (start ? S_RECON : S_IDLE) :
                 state == S_RECON ? (res_acc && idx == 4'd15 ? S_DRAIN : S_RECON) :
                 state == S_DRAIN ? (pix_take ? S_DONE : S_DRAIN) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_idx <= '0;
      mode_q <= M_V;
      top_q <= '0;
      left_q <= '0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        mode_q <= mode_e'(mode);
        top_q <= top;
        left_q <= left;
        idx <= '0;
      end
      if (pix_take) pix_valid <= 1'b0;
      if (res_acc) begin
        pix_valid <= 1'b1;
        pix_data <= pix_nx;
        pix_idx <= idx;
        idx <= idx + 4'd1;
      end
    end
  end
`ifdef RECON_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_bottom <= '0;
      edge_right <= '0;
    end else if (res_acc) begin
      if (idx[3:2] == 2'd3) edge_bottom[{idx[1:0], 3'b000} +: 8] <= pix_nx;
      if (idx[1:0] == 2'd3) edge_right[{idx[3:2], 3'b000} +: 8] <= pix_nx;
    end
  end
`endif
endmodule

// File: tb/tb_recon_luma4x4.sv
// tb_recon_luma4x4: scoreboard bench for recon_luma4x4 with directed blocks (RECON_EDGE_EN adds edge checks)
module tb_recon_luma4x4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic [2:0] mode = '0;
  logic [63:0] top = '0;
  logic [39:0] left = '0;
  logic res_valid = 1'b0;
  logic [8:0] res_data = '0;
  logic res_ready, pix_valid, busy, done;
  logic [7:0] pix_data;
  logic [3:0] pix_idx;
  logic pix_ready;
`ifdef RECON_EDGE_EN
  logic [31:0] edge_bottom, edge_right;
`endif
  typedef struct {int idx; int data;} exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int res_v[16];
  int exp_v[16];
  logic tog = 1'b0;
  logic fin_req = 1'b0;
  logic rst_prev = 1'b0;
  logic exp_done = 1'b0;
  logic exp_n;
  logic hold = 1'b0;
  logic fin_seen = 1'b0;
  logic [11:0] h_pix = '0;
  logic [31:0] m_eb = '0;
  logic [31:0] m_er = '0;
  exp_t e;

  always #5 clk = ~clk;

  recon_luma4x4 dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode), .top(top), .left(left),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_idx(pix_idx), .pix_ready(pix_ready),
`ifdef RECON_EDGE_EN
    .edge_bottom(edge_bottom), .edge_right(edge_right),
`endif
    .busy(busy), .done(done)
  );

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = tog ? ~pix_ready : 1'b1;
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_prev) chk("reset_state", {res_ready, pix_valid, pix_data, pix_idx, busy, done}, 64'd0);
    if (done || exp_done) chk("done_busy", {done, busy}, {exp_done, 1'b0});
`ifdef RECON_EDGE_EN
    if (done) begin
      chk("edge_bottom", edge_bottom, m_eb);
      chk("edge_right", edge_right, m_er);
    end
`endif
    if (hold) chk("hold", {pix_valid, pix_idx, pix_data}, {1'b1, h_pix});
    if (!reset && (!enable || (pix_valid && !pix_ready))) chk("rdy_stall", res_ready, 1'b0);
    exp_n = 1'b0;
    if (reset) begin
      sb.delete();
      m_eb = '0;
      m_er = '0;
      hold = 1'b0;
    end else begin
      if (enable && pix_valid && pix_ready) begin
        if (sb.size() == 0) chk("extra_pix", {pix_idx, pix_data}, 64'hdead);
        else begin
          e = sb.pop_front();
          chk("pix_idx", pix_idx, e.idx);
          chk("pix_data", pix_data, e.data);
          chk("busy", busy, 1'b1);
          if (e.idx >= 12) m_eb[8*(e.idx-12) +: 8] = 8'(e.data);
          if (e.idx % 4 == 3) m_er[8*(e.idx/4) +: 8] = 8'(e.data);
          exp_n = e.idx == 15;
        end
      end
      hold = pix_valid && !(pix_ready && enable);
      h_pix = {pix_idx, pix_data};
    end
    exp_done = exp_n;
    rst_prev = reset;
    if (fin_req && !fin_seen) begin
      chk("leftover", sb.size(), 0);
      fin_seen = 1'b1;
    end
  end

  // Closed forms for an edge holding L,K,J,I,M,A..H = 0,10,..,120.
  function automatic int exp_lin(input int m, input int x, input int y);
    int z, k;
    case (m)
      2: return (x == 3 && y == 3) ? 118 : 60 + 10 * (x + y);
      3: return 10 * (4 + x - y);
      4: begin
        z = 2 * x - y;
        k = x - (y >> 1);
        return z < -1 ? 10 * (5 - y) : (z >= 0 && z % 2 == 0) ? 45 + 10 * k : 40 + 10 * k;
      end
      5: begin
        z = 2 * y - x;
        k = y - (x >> 1);
        return z < -1 ? 30 + 10 * x : (z >= 0 && z % 2 == 0) ? 35 - 10 * k : 40 - 10 * k;
      end
      6: begin
        k = x + (y >> 1);
        return y % 2 == 0 ? 55 + 10 * k : 60 + 10 * k;
      end
      default: begin
        z = x + 2 * y;
        k = y + (x >> 1);
        return z > 5 ? 0 : z == 5 ? 3 : z % 2 == 0 ? 25 - 10 * k : 20 - 10 * k;
      end
    endcase
  endfunction

  // sa: start pulse injected at that residual, ra: reset before that residual, sta: enable stall there.
  task automatic run(input logic [2:0] m, input logic [63:0] t, input logic [39:0] l,
                     input int sa, input int ra, input int sta);
    int n;
    logic acc;
    for (int i = 0; i < 16; i++) sb.push_back('{i, exp_v[i]});
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = m;
    top = t;
    left = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m;
    top = ~t;
    left = ~l;
    for (int i = 0; i < 16; i++) begin
      res_valid = 1'b1;
      res_data = 9'(res_v[i]);
      if (i == ra) begin
        res_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (i == sta) begin
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
      end
      if (i == sa) begin
        start = 1'b1;
        mode = 3'd1;
        top = '1;
      end
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = res_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        n++;
      end
      if (!acc) begin
        $display("FAIL feed_timeout idx=%0d", i);
        $fatal(1, "residual stream stuck");
      end
    end
    res_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      $display("FAIL done_timeout act=0 req=1");
      $fatal(1, "block never completed");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin res_v[i] = 0; exp_v[i] = 10 * (i % 4 + 1); end
    run(3'd0, {32'd0, 8'd40, 8'd30, 8'd20, 8'd10}, 40'd0, -1, -1, -1);
    for (int i = 0; i < 16; i++) begin
      res_v[i] = i < 4 ? 10 : i < 8 ? -10 : 0;
      exp_v[i] = i < 4 ? 255 : i < 8 ? 0 : i < 12 ? 77 : 88;
    end
    run(3'd1, 64'd0, {8'd88, 8'd77, 8'd5, 8'd250, 8'd0}, -1, -1, -1);
    for (int i = 0; i < 16; i++) begin res_v[i] = i; exp_v[i] = 100 + i; end
    run(3'd2, {8{8'd100}}, 40'd0, -1, -1, 6);
    for (int m = 2; m < 8; m++) begin
      for (int i = 0; i < 16; i++) begin res_v[i] = 0; exp_v[i] = exp_lin(m, i % 4, i / 4); end
      tog = m == 6;
      run(3'(m), {8'd120, 8'd110, 8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50},
          {8'd0, 8'd10, 8'd20, 8'd30, 8'd40}, -1, -1, -1);
    end
    tog = 1'b0;
    for (int i = 0; i < 16; i++) begin res_v[i] = 0; exp_v[i] = 10 * (i % 4 + 1); end
    run(3'd0, {32'd0, 8'd40, 8'd30, 8'd20, 8'd10}, 40'd0, 7, -1, -1);
    run(3'd0, {32'd0, 8'd40, 8'd30, 8'd20, 8'd10}, 40'd0, -1, 9, -1);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin res_v[i] = 0; exp_v[i] = 60; end
    run(3'd7, 64'd0, {8'd60, 8'd60, 8'd60, 8'd60, 8'd0}, -1, -1, -1);
    fin_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
